// File: rtl/fc2_dot_accumulator.sv
// fc2_dot_accumulator: joins activation and weight beats, reduces their element-wise products
// over IN_DEPTH beats and emits one full-precision signed result on a valid/ready output.
module fc2_dot_accumulator #(
    parameter int DATA_IN_PRECISION_0  = 8,
    parameter int WEIGHT_PRECISION_0   = 8,
    parameter int PARALLELISM          = 4,
    parameter int IN_DEPTH             = 8,
    parameter int DATA_OUT_PRECISION_0 = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0 + $clog2(PARALLELISM * IN_DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic signed [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM-1:0],
    input  logic                                   data_in_valid,
    output logic                                   data_in_ready,
    input  logic signed [WEIGHT_PRECISION_0-1:0]   weight [PARALLELISM-1:0],
    input  logic                                   weight_valid,
    output logic                                   weight_ready,
    output logic signed [DATA_OUT_PRECISION_0-1:0] data_out,
    output logic                                   data_out_valid,
    input  logic                                   data_out_ready
);
    localparam int OW = DATA_OUT_PRECISION_0;
    localparam int CW = $clog2(IN_DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_DEPTH - 1);

    logic signed [OW-1:0] acc_q, acc_d, out_q, out_d, beat_sum;
    logic [CW-1:0] cnt_q, cnt_d;
    logic valid_q, valid_d, can_accept, fire, last;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < PARALLELISM; i++)
            beat_sum = beat_sum + OW'(data_in[i]) * OW'(weight[i]);
    end

    // Reset counts as an empty output register so the readies never stall on a stale result.
    assign can_accept    = rst || !valid_q || data_out_ready;
    assign data_in_ready = weight_valid && can_accept;
    assign weight_ready  = data_in_valid && can_accept;
    assign fire          = data_in_valid && weight_valid && can_accept;
    assign last          = fire && (cnt_q == LAST);

    always_comb begin
        acc_d   = fire ? (last ? '0 : acc_q + beat_sum) : acc_q;
        cnt_d   = fire ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        out_d   = last ? acc_q + beat_sum : out_q;
        valid_d = last ? 1'b1 : (data_out_ready ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = valid_q;
endmodule
